pwrmgr_slow_seq: RTL and testbench

Parametrised slow-domain power sequencer. It generalises the single-domain slow power FSM to NumPd switchable power domains and NumClks clock sources, with per-domain keep-on configuration and ordered power-up/down. It adds a settle-timeout watchdog that drives a terminal fault state. It sits in the always-on slow clock domain, handshakes with the fast FSM and drives the AST power, clamp and clock-enable controls.

---
 rtl/pwrmgr_slow_seq.sv | 209 ++++++++++++++++++++
 tb/tb_pwrmgr_slow_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwrmgr_slow_seq.sv
// Slow-domain power sequencer: ordered multi-domain power-up/down, clamp and clock
// control, fast-FSM handshakes, and a settle-timeout watchdog with a terminal fault state.
module pwrmgr_slow_seq #(
  parameter int unsigned NumPd         = 2,
  parameter int unsigned NumClks       = 3,
  parameter int unsigned TimeoutW      = 8,
  parameter int unsigned TimeoutCycles = 200
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wakeup_i,
  input  logic               reset_req_i,
  output logic               req_pwrup_o,
  output logic [1:0]         pwrup_cause_o,
  output logic               pwrup_cause_toggle_o,
  input  logic               ack_pwrup_i,
  input  logic               req_pwrdn_i,
  output logic               ack_pwrdn_o,
  input  logic [NumPd-1:0]   pd_keep_i,
  input  logic [NumClks-1:0] clk_en_active_i,
  input  logic [NumClks-1:0] clk_en_lp_i,
  input  logic [NumPd-1:0]   pok_i,
  input  logic [NumClks-1:0] clk_val_i,
  output logic [NumPd-1:0]   pd_n_o,
  output logic [NumPd-1:0]   clamp_o,
  output logic [NumClks-1:0] clk_en_o,
  output logic               fault_o
);

  localparam int unsigned IdxW = (NumPd > 1) ? $clog2(NumPd) : 1;
  localparam logic [IdxW-1:0]     LastIdx    = IdxW'(NumPd - 1);
  localparam logic [TimeoutW-1:0] TimeoutLim = TimeoutW'(TimeoutCycles);
  localparam bit                  WdogEn     = (TimeoutCycles != 0);

  localparam logic [1:0] CausePor   = 2'd0;
  localparam logic [1:0] CauseWake  = 2'd1;
  localparam logic [1:0] CauseReset = 2'd2;

  typedef enum logic [3:0] {
    StReset, StLowPower, StPdOn, StClampOff, StClocksOn, StReqPwrUp,
    StIdle, StAckPwrDn, StClocksOff, StClampOn, StPdOff, StFault
  } state_e;

  state_e               r_state, w_state_nxt;
  logic [IdxW-1:0]      r_idx, w_idx_nxt;
  logic [TimeoutW-1:0]  r_timer, w_timer_nxt;
  logic [NumPd-1:0]     r_pd_n, w_pd_n_nxt, r_clamp, w_clamp_nxt;
  logic [NumClks-1:0]   r_clk_en, w_clk_en_nxt;
  logic                 r_req, w_req_nxt, r_ack, w_ack_nxt;
  logic [1:0]           r_cause, w_cause_nxt;
  logic                 r_toggle, w_toggle_nxt, r_fault, w_fault_nxt;
  logic                 w_wait, w_adv;
  logic                 w_pok_idx, w_keep_idx, w_clk_on_ok, w_clk_off_ok;

  assign w_pok_idx    = pok_i[r_idx];
  assign w_keep_idx   = pd_keep_i[r_idx];
  assign w_clk_on_ok  = &(clk_val_i | ~clk_en_active_i);
  assign w_clk_off_ok = &(~clk_val_i | clk_en_lp_i);

  // State register and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= StReset;
      r_idx    <= '0;
      r_timer  <= '0;
      r_pd_n   <= '1;
      r_clamp  <= '0;
      r_clk_en <= '0;
      r_req    <= 1'b0;
      r_ack    <= 1'b0;
      r_cause  <= CausePor;
      r_toggle <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_timer  <= w_timer_nxt;
      r_pd_n   <= w_pd_n_nxt;
      r_clamp  <= w_clamp_nxt;
      r_clk_en <= w_clk_en_nxt;
      r_req    <= w_req_nxt;
      r_ack    <= w_ack_nxt;
      r_cause  <= w_cause_nxt;
      r_toggle <= w_toggle_nxt;
      r_fault  <= w_fault_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_pd_n_nxt   = r_pd_n;
    w_clamp_nxt  = r_clamp;
    w_clk_en_nxt = r_clk_en;
    w_req_nxt    = r_req;
    w_ack_nxt    = r_ack;
    w_cause_nxt  = r_cause;
    w_toggle_nxt = r_toggle;
    w_fault_nxt  = r_fault;
    w_wait       = 1'b0;
    w_adv        = 1'b0;
    w_timer_nxt  = r_timer;

    case (r_state)
      StReset: begin
        w_state_nxt = StPdOn;
        w_idx_nxt   = '0;
        w_cause_nxt = CausePor;
      end
      StLowPower: begin
        if (wakeup_i || reset_req_i) begin
          w_state_nxt  = StPdOn;
          w_idx_nxt    = '0;
          w_toggle_nxt = ~r_toggle;
          w_cause_nxt  = reset_req_i ? CauseReset : CauseWake;
        end
      end
      StPdOn: begin
        w_wait             = 1'b1;
        w_adv              = w_pok_idx;
        w_pd_n_nxt[r_idx]  = 1'b1;
        if (w_adv) begin
          if (r_idx == LastIdx) w_state_nxt = StClampOff;
          else                  w_idx_nxt   = r_idx + 1'b1;
        end
      end
      StClampOff: begin
        w_clamp_nxt = '0;
        w_state_nxt = StClocksOn;
      end
      StClocksOn: begin
        w_wait       = 1'b1;
        w_adv        = w_clk_on_ok;
        w_clk_en_nxt = clk_en_active_i;
        if (w_adv) w_state_nxt = StReqPwrUp;
      end
      StReqPwrUp: begin
        w_req_nxt = 1'b1;
        if (ack_pwrup_i && !req_pwrdn_i) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = StIdle;
        end
      end
      StIdle: begin
        w_clk_en_nxt = clk_en_active_i;
        if (req_pwrdn_i && !ack_pwrup_i) w_state_nxt = StAckPwrDn;
      end
      StAckPwrDn: begin
        w_ack_nxt = 1'b1;
        if (!req_pwrdn_i) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = StClocksOff;
        end
      end
      StClocksOff: begin
        w_wait       = 1'b1;
        w_adv        = w_clk_off_ok;
        w_clk_en_nxt = clk_en_lp_i;
        if (w_adv) w_state_nxt = StClampOn;
      end
      StClampOn: begin
        w_clamp_nxt = ~pd_keep_i;
        w_idx_nxt   = LastIdx;
        w_state_nxt = StPdOff;
      end
      StPdOff: begin
        w_wait            = 1'b1;
        w_adv             = w_keep_idx || !w_pok_idx;
        w_pd_n_nxt[r_idx] = w_keep_idx;
        if (w_adv) begin
          if (r_idx == '0) w_state_nxt = StLowPower;
          else             w_idx_nxt   = r_idx - 1'b1;
        end
      end
      StFault: begin
        w_state_nxt = StFault;
      end
      default: begin
        w_state_nxt = StFault;
      end
    endcase

    // Settle watchdog: only waiting states count, and only when still not settled
    if (WdogEn && w_wait && !w_adv && (r_timer == TimeoutLim)) w_state_nxt = StFault;

    if (w_state_nxt == StFault) begin
      w_pd_n_nxt   = '0;
      w_clamp_nxt  = '1;
      w_clk_en_nxt = '0;
      w_req_nxt    = 1'b0;
      w_ack_nxt    = 1'b0;
      w_fault_nxt  = 1'b1;
    end

    if ((w_state_nxt != r_state) || (w_idx_nxt != r_idx)) w_timer_nxt = '0;
    else if (w_wait && (r_timer != '1))                   w_timer_nxt = r_timer + 1'b1;
  end

  assign req_pwrup_o          = r_req;
  assign pwrup_cause_o        = r_cause;
  assign pwrup_cause_toggle_o = r_toggle;
  assign ack_pwrdn_o          = r_ack;
  assign pd_n_o               = r_pd_n;
  assign clamp_o              = r_clamp;
  assign clk_en_o             = r_clk_en;
  assign fault_o              = r_fault;

endmodule

// File: tb/tb_pwrmgr_slow_seq.sv
// Directed bench for pwrmgr_slow_seq with a small AST response model and an
// expectation queue popped as each DUT response is observed.
module tb_pwrmgr_slow_seq;

  logic       clk = 1'b0;
  logic       rst, rst_nt;
  logic       wakeup, reset_req, ack_pwrup, req_pwrdn;
  logic [1:0] pd_keep;
  logic [2:0] clk_en_active, clk_en_lp;
  logic [1:0] pok;
  logic [2:0] clk_val;

  logic       req_pwrup, toggle, ack_pwrdn, fault;
  logic [1:0] cause, pd_n, clamp;
  logic [2:0] clk_en;
  logic       req_pwrup_nt, toggle_nt, ack_pwrdn_nt, fault_nt;
  logic [1:0] cause_nt, pd_n_nt, clamp_nt;
  logic [2:0] clk_en_nt;

  logic       use_nt, val_hold_low;
  logic [1:0] pok_stuck;

  int total = 0;
  int bad   = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pwrmgr_slow_seq #(.NumPd(2), .NumClks(3), .TimeoutW(8), .TimeoutCycles(200)) dut (
    .clk_i(clk), .rst_i(rst), .wakeup_i(wakeup), .reset_req_i(reset_req),
    .req_pwrup_o(req_pwrup), .pwrup_cause_o(cause), .pwrup_cause_toggle_o(toggle),
    .ack_pwrup_i(ack_pwrup), .req_pwrdn_i(req_pwrdn), .ack_pwrdn_o(ack_pwrdn),
    .pd_keep_i(pd_keep), .clk_en_active_i(clk_en_active), .clk_en_lp_i(clk_en_lp),
    .pok_i(pok), .clk_val_i(clk_val), .pd_n_o(pd_n), .clamp_o(clamp),
    .clk_en_o(clk_en), .fault_o(fault));

  pwrmgr_slow_seq #(.NumPd(2), .NumClks(3), .TimeoutW(8), .TimeoutCycles(0)) dut_nt (
    .clk_i(clk), .rst_i(rst_nt), .wakeup_i(wakeup), .reset_req_i(reset_req),
    .req_pwrup_o(req_pwrup_nt), .pwrup_cause_o(cause_nt), .pwrup_cause_toggle_o(toggle_nt),
    .ack_pwrup_i(ack_pwrup), .req_pwrdn_i(req_pwrdn), .ack_pwrdn_o(ack_pwrdn_nt),
    .pd_keep_i(pd_keep), .clk_en_active_i(clk_en_active), .clk_en_lp_i(clk_en_lp),
    .pok_i(pok), .clk_val_i(clk_val), .pd_n_o(pd_n_nt), .clamp_o(clamp_nt),
    .clk_en_o(clk_en_nt), .fault_o(fault_nt));

  // AST model: power-ok and clock-valid follow the enables one cycle later
  always @(posedge clk) begin
    pok     <= (use_nt ? pd_n_nt : pd_n) & ~pok_stuck;
    clk_val <= val_hold_low ? 3'b000 : (use_nt ? clk_en_nt : clk_en);
  end

  wire [12:0] obs = {fault, toggle, cause, req_pwrup, ack_pwrdn, clk_en, clamp, pd_n};

  task automatic push(input string tag, input logic [31:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] observed);
    string       t;
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%0h expected=none", observed);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (observed === e) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", t, observed, e);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for the power-up request, acknowledge it, and check it drops
  task automatic pwrup_handshake(input string tag);
    push({tag, "_req_up"}, 32'd1);
    for (int k = 0; k < 60; k++) begin
      if (req_pwrup) break;
      @(negedge clk);
    end
    pop_chk(32'(req_pwrup));
    push({tag, "_pd_clk"}, {27'd0, 3'b111, 2'b11});
    pop_chk(32'({clk_en, pd_n}));
    ack_pwrup = 1'b1;
    push({tag, "_req_dn"}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!req_pwrup) break;
    end
    pop_chk(32'(req_pwrup));
    ack_pwrup = 1'b0;
    cyc(2);
  endtask

  // Full power-down to low power with domain 0 kept on
  task automatic pwrdn_seq(input string tag);
    req_pwrdn = 1'b1;
    push({tag, "_ack_up"}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ack_pwrdn) break;
    end
    pop_chk(32'(ack_pwrdn));
    req_pwrdn = 1'b0;
    push({tag, "_ack_dn"}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!ack_pwrdn) break;
    end
    pop_chk(32'(ack_pwrdn));
    push({tag, "_pd1_off"}, 32'd0);
    for (int k = 0; k < 40; k++) begin
      if (!pd_n[1]) break;
      @(negedge clk);
    end
    pop_chk(32'(pd_n[1]));
    cyc(10);
    push({tag, "_lp_outs"}, {24'd0, 1'b0, 3'b001, 2'b10, 2'b01});
    pop_chk(32'({fault, clk_en, clamp, pd_n}));
  endtask

  initial begin
    int n;
    int cl_cyc;
    int ce_cyc;

    rst = 1'b1;  rst_nt = 1'b1;
    wakeup = 1'b0; reset_req = 1'b0; ack_pwrup = 1'b0; req_pwrdn = 1'b0;
    pd_keep = 2'b01; clk_en_active = 3'b111; clk_en_lp = 3'b001;
    use_nt = 1'b0; val_hold_low = 1'b0; pok_stuck = 2'b00;
    cyc(3);

    push("reset_vals", 32'h003);
    pop_chk(32'(obs));
    rst = 1'b0;

    // Cold boot
    pwrup_handshake("boot");
    push("boot_cause", 32'd0);
    pop_chk(32'({toggle, cause}));

    pwrdn_seq("pd1");

    // Simultaneous wakeup and reset request: reset wins
    wakeup = 1'b1; reset_req = 1'b1;
    @(negedge clk);
    wakeup = 1'b0; reset_req = 1'b0;
    push("wake_cause", {29'd0, 1'b1, 2'd2});
    pop_chk(32'({toggle, cause}));
    cl_cyc = -1; ce_cyc = -1;
    for (int k = 0; k < 40; k++) begin
      if (cl_cyc < 0 && clamp == 2'b00) cl_cyc = k;
      if (ce_cyc < 0 && clk_en == 3'b111) ce_cyc = k;
      if (req_pwrup) break;
      @(negedge clk);
    end
    push("clamp_before_clk", 32'd1);
    pop_chk(32'((cl_cyc >= 0) && (ce_cyc > cl_cyc)));
    pwrup_handshake("wake");

    pwrdn_seq("pd2");

    // Domain 1 never reports power-ok: watchdog must fire
    pok_stuck = 2'b10;
    wakeup = 1'b1;
    n = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      wakeup = 1'b0;
      n++;
      if (fault) break;
    end
    push("timeout_cycle", 32'd1);
    pop_chk(32'((n >= 195) && (n <= 210)));
    push("fault_outs", {24'd0, 1'b1, 3'b000, 2'b11, 2'b00});
    pop_chk(32'({fault, clk_en, clamp, pd_n}));
    pok_stuck = 2'b00;
    cyc(20);
    wakeup = 1'b1;
    cyc(2);
    wakeup = 1'b0;
    cyc(5);
    push("fault_sticky", {24'd0, 1'b1, 1'b0, 1'b0, 3'b000, 2'b11, 2'b00});
    pop_chk(32'({fault, req_pwrup, ack_pwrdn, clk_en, clamp, pd_n}));

    // Watchdog disabled: clocks never valid for 1000 cycles
    rst = 1'b1;
    use_nt = 1'b1; val_hold_low = 1'b1;
    cyc(2);
    rst_nt = 1'b0;
    cyc(1000);
    push("nt_no_fault", 32'd0);
    pop_chk(32'({fault_nt, req_pwrup_nt}));
    push("nt_waiting_clk", {29'd0, 3'b111});
    pop_chk(32'(clk_en_nt));
    val_hold_low = 1'b0;
    push("nt_req_up", 32'd1);
    for (int k = 0; k < 20; k++) begin
      if (req_pwrup_nt) break;
      @(negedge clk);
    end
    pop_chk(32'(req_pwrup_nt));
    rst_nt = 1'b1;
    use_nt = 1'b0;
    cyc(2);

    // Reset asserted during the power-down acknowledge
    rst = 1'b0;
    pwrup_handshake("boot2");
    req_pwrdn = 1'b1;
    push("ack_before_rst", 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ack_pwrdn) break;
    end
    pop_chk(32'(ack_pwrdn));
    #2 rst = 1'b1;
    #1;
    push("async_rst_vals", 32'h003);
    pop_chk(32'(obs));
    @(negedge clk);
    req_pwrdn = 1'b0;
    rst = 1'b0;
    pwrup_handshake("reboot");
    push("reboot_cause", 32'd0);
    pop_chk(32'({fault, toggle, cause}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
